// File: rtl/iis_pkg.sv
// Shared definitions for the IIS transmit sequencer: register map, bit
// positions, FSM encoding and serializer control codes.
package iis_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_LEN    = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;
  localparam logic [3:0] ADDR_THRESH = 4'hC;

  localparam int CTRL_START  = 0;
  localparam int CTRL_STOP   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_CONT   = 3;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_UNDERRUN = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } iis_state_e;

  localparam logic [2:0] SC_OFF = 3'b000;
  localparam logic [2:0] SC_RUN = 3'b101;

endpackage

// File: rtl/iis_tx_regs.sv
// APB register block for the IIS transmit sequencer: decode, storage,
// self-clearing command bits, sticky W1C flags and the read mux.
module iis_tx_regs
  import iis_pkg::*;
#(
  parameter int LVL_W = 7,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [3:0]       paddr,
  input  logic [31:0]      pwdata,
  output logic [31:0]      prdata,
  output logic             pslverr,
  input  logic             busy,
  input  logic [CNT_W-1:0] words_sent,
  input  logic             done_set,
  input  logic             underrun_set,
  output logic             start,
  output logic             stop,
  output logic [CNT_W-1:0] len,
  output logic [LVL_W-1:0] thresh,
  output logic             cont,
  output logic             irq
);

  logic        wr;
  logic        wr_ctrl;
  logic        start_req;
  logic        irq_en;
  logic        done;
  logic        underrun;
  logic [15:0] words_16;
  logic        unused_pwdata;

  assign wr        = psel & penable & pwrite;
  assign wr_ctrl   = wr & (paddr == ADDR_CTRL);
  assign start_req = wr_ctrl & pwdata[CTRL_START];

  // A start that writes CONT=1 in the same access is accepted even with LEN=0.
  assign start   = start_req & ((len != '0) | pwdata[CTRL_CONT]);
  assign stop    = wr_ctrl & pwdata[CTRL_STOP];
  assign pslverr = start_req & ~busy & (len == '0) & ~pwdata[CTRL_CONT];

  assign words_16      = 16'(words_sent);
  assign unused_pwdata = &{1'b0, pwdata[31:CNT_W]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en   <= 1'b0;
      cont     <= 1'b0;
      len      <= '0;
      thresh   <= LVL_W'(1);
      done     <= 1'b0;
      underrun <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        irq_en <= pwdata[CTRL_IRQ_EN];
        cont   <= pwdata[CTRL_CONT];
      end
      if (wr && paddr == ADDR_LEN)    len    <= pwdata[CNT_W-1:0];
      if (wr && paddr == ADDR_THRESH) thresh <= pwdata[LVL_W-1:0];

      // A flag-set event in the same cycle as its W1C wins.
      if (done_set)
        done <= 1'b1;
      else if (wr && paddr == ADDR_STATUS && pwdata[STAT_DONE])
        done <= 1'b0;

      if (underrun_set)
        underrun <= 1'b1;
      else if (wr && paddr == ADDR_STATUS && pwdata[STAT_UNDERRUN])
        underrun <= 1'b0;

      irq <= irq_en & (done | underrun);
    end
  end

  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      case (paddr)
        ADDR_CTRL: begin
          prdata[CTRL_IRQ_EN] = irq_en;
          prdata[CTRL_CONT]   = cont;
        end
        ADDR_LEN:    prdata = 32'(len);
        ADDR_STATUS: prdata = {words_16, 13'b0, underrun, done, busy};
        ADDR_THRESH: prdata = 32'(thresh);
        default:     prdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/iis_tx_ctrl.sv
// IIS transmit sequencer: primes the TX FIFO to a threshold, enables the
// serializer, counts words and stops on a word boundary.
module iis_tx_ctrl
  import iis_pkg::*;
#(
  parameter int LVL_W = 7,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [3:0]       paddr,
  input  logic [31:0]      pwdata,
  output logic [31:0]      prdata,
  output logic             pready,
  output logic             pslverr,
  input  logic [LVL_W-1:0] fifo_level,
  input  logic             fifo_empty,
  input  logic             word_strobe,
  output logic [2:0]       send_ctrl,
  output logic             busy,
  output logic             irq
);

  iis_state_e       state;
  iis_state_e       state_nxt;
  logic [CNT_W-1:0] words_sent;
  logic [CNT_W-1:0] words_inc;
  logic             clr_cnt;
  logic             inc_cnt;
  logic             done_set;
  logic             underrun_set;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] len;
  logic [LVL_W-1:0] thresh;
  logic             cont;

  assign pready    = 1'b1;
  assign busy      = (state != ST_IDLE);
  assign words_inc = words_sent + {{(CNT_W-1){1'b0}}, 1'b1};

  iis_tx_regs #(
    .LVL_W(LVL_W),
    .CNT_W(CNT_W)
  ) u_regs (
    .clk         (clk),
    .rst         (rst),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pslverr     (pslverr),
    .busy        (busy),
    .words_sent  (words_sent),
    .done_set    (done_set),
    .underrun_set(underrun_set),
    .start       (start),
    .stop        (stop),
    .len         (len),
    .thresh      (thresh),
    .cont        (cont),
    .irq         (irq)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      words_sent <= '0;
      send_ctrl  <= SC_OFF;
    end else begin
      state <= state_nxt;
      if (clr_cnt)
        words_sent <= '0;
      else if (inc_cnt)
        words_sent <= words_inc;
      send_ctrl <= (state_nxt == ST_RUN || state_nxt == ST_DRAIN) ? SC_RUN : SC_OFF;
    end
  end

  // In RUN the priority is underrun, then length reached, then STOP.
  always_comb begin
    state_nxt    = state;
    clr_cnt      = 1'b0;
    inc_cnt      = 1'b0;
    done_set     = 1'b0;
    underrun_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_PRIME;
          clr_cnt   = 1'b1;
        end
      end
      ST_PRIME: begin
        if (stop)
          state_nxt = ST_IDLE;
        else if (fifo_level >= thresh)
          state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (word_strobe) begin
          inc_cnt = 1'b1;
          if (fifo_empty) begin
            underrun_set = 1'b1;
            state_nxt    = ST_IDLE;
          end else if (!cont && words_inc == len) begin
            done_set  = 1'b1;
            state_nxt = ST_IDLE;
          end else if (stop) begin
            state_nxt = ST_DRAIN;
          end
        end else if (stop) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (word_strobe) begin
          inc_cnt   = 1'b1;
          done_set  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_iis_tx_ctrl.sv
// Bench for iis_tx_ctrl: directed scenarios plus randomized runs, checked
// every cycle against a transaction-level model of the sequencer.
module tb_iis_tx_ctrl;

  localparam int LVL_W = 7;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             psel = 1'b0;
  logic             penable = 1'b0;
  logic             pwrite = 1'b0;
  logic [3:0]       paddr = '0;
  logic [31:0]      pwdata = '0;
  logic [31:0]      prdata;
  logic             pready;
  logic             pslverr;
  logic [LVL_W-1:0] fifo_level = '0;
  logic             fifo_empty = 1'b0;
  logic             word_strobe = 1'b0;
  logic [2:0]       send_ctrl;
  logic             busy;
  logic             irq;

  int checks = 0;
  int errors = 0;

  iis_tx_ctrl #(.LVL_W(LVL_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .fifo_level (fifo_level),
    .fifo_empty (fifo_empty),
    .word_strobe(word_strobe),
    .send_ctrl  (send_ctrl),
    .busy       (busy),
    .irq        (irq)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: a run is active, then either priming or sending,
  // and a sending run may be winding down after a stop request.
  bit          m_active, m_sending, m_winding;
  bit          m_done, m_under, m_irq, m_irq_en, m_cont;
  logic [15:0] m_words, m_len;
  logic [6:0]  m_thresh;

  always @(posedge clk or negedge rst) begin : model
    bit wr, st, sp, set_done, set_under, old_cont;
    logic [15:0] old_len, next_words;
    logic [6:0]  old_thresh;
    if (!rst) begin
      m_active = 0; m_sending = 0; m_winding = 0;
      m_done = 0; m_under = 0; m_irq = 0; m_irq_en = 0; m_cont = 0;
      m_words = 0; m_len = 0; m_thresh = 7'd1;
    end else begin
      wr = psel && penable && pwrite;
      st = wr && paddr == 4'h0 && pwdata[0];
      sp = wr && paddr == 4'h0 && pwdata[1];
      set_done = 0; set_under = 0;
      old_cont = m_cont; old_len = m_len; old_thresh = m_thresh;
      m_irq = m_irq_en && (m_done || m_under);
      next_words = m_words + 16'd1;
      if (!m_active) begin
        if (st && (m_len != 0 || pwdata[3])) begin
          m_active = 1; m_words = 0;
        end
      end else if (!m_sending) begin
        if (sp) m_active = 0;
        else if (7'(fifo_level) >= old_thresh) m_sending = 1;
      end else if (!m_winding) begin
        if (word_strobe) begin
          m_words = next_words;
          if (fifo_empty) begin
            set_under = 1; m_active = 0; m_sending = 0;
          end else if (!old_cont && next_words == old_len) begin
            set_done = 1; m_active = 0; m_sending = 0;
          end else if (sp) m_winding = 1;
        end else if (sp) m_winding = 1;
      end else if (word_strobe) begin
        m_words = next_words;
        set_done = 1; m_active = 0; m_sending = 0; m_winding = 0;
      end
      if (wr) begin
        case (paddr)
          4'h0: begin m_irq_en = pwdata[2]; m_cont = pwdata[3]; end
          4'h4: m_len = pwdata[15:0];
          4'h8: begin
            if (pwdata[1]) m_done = 0;
            if (pwdata[2]) m_under = 0;
          end
          4'hC: m_thresh = pwdata[6:0];
          default: ;
        endcase
      end
      if (set_done) m_done = 1;
      if (set_under) m_under = 1;
    end
  end

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'h0: return {28'b0, m_cont, m_irq_en, 2'b00};
      4'h4: return {16'b0, m_len};
      4'h8: return {m_words, 13'b0, m_under, m_done, m_active};
      4'hC: return {25'b0, m_thresh};
      default: return 32'b0;
    endcase
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      check("send_ctrl", 32'(send_ctrl), m_sending ? 32'd5 : 32'd0);
      check("busy", 32'(busy), 32'(m_active));
      check("irq", 32'(irq), 32'(m_irq));
      check("pready", 32'(pready), 32'd1);
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    word_strobe = 1'b0;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d, output logic err);
    logic exp_err;
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    tick();
    penable = 1;
    #3;
    exp_err = (a == 4'h0) && d[0] && !m_active && m_len == 0 && !d[3];
    err = pslverr;
    check("pslverr", 32'(pslverr), 32'(exp_err));
    tick();
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic e;
    apb_write(a, d, e);
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    tick();
    penable = 1;
    #3;
    d = prdata;
    check($sformatf("read_0x%0h", a), prdata, model_read(a));
    tick();
    psel = 0; penable = 0;
  endtask

  task automatic strobe_word(input logic empty);
    fifo_empty = empty;
    word_strobe = 1'b1;
    tick();
    fifo_empty = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        err;
    logic        cont_r, irq_en_r;

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // reset state
    check("reset_send_ctrl", 32'(send_ctrl), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    apb_read(4'hC, rd); check("reset_thresh", rd, 32'd1);
    apb_read(4'h4, rd); check("reset_len", rd, 32'd0);
    apb_read(4'h8, rd); check("reset_status", rd, 32'd0);

    // 1: length-terminated run with threshold priming and irq
    wr(4'h4, 32'd4);
    wr(4'hC, 32'd3);
    wr(4'h0, 32'h5);
    for (int l = 0; l < 3; l++) begin
      fifo_level = 7'(l);
      tick();
    end
    check("prime_held_off", 32'(send_ctrl), 32'd0);
    fifo_level = 7'd3;
    tick();
    #3 check("run_enable", 32'(send_ctrl), 32'd5);
    for (int i = 0; i < 4; i++) strobe_word(1'b0);
    check("len_done_busy", 32'(busy), 32'd0);
    check("len_done_send", 32'(send_ctrl), 32'd0);
    check("len_done_irq", 32'(irq), 32'd1);
    apb_read(4'h8, rd); check("len_done_status", rd, 32'h0004_0002);
    wr(4'h8, 32'h2);
    tick();
    check("irq_cleared", 32'(irq), 32'd0);

    // 2: start with zero length is refused
    wr(4'h4, 32'd0);
    wr(4'h0, 32'h4);
    apb_write(4'h0, 32'h5, err);
    check("start_len0_pslverr", 32'(err), 32'd1);
    tick();
    check("start_len0_busy", 32'(busy), 32'd0);

    // 3: continuous mode, stop mid-word drains one more word
    wr(4'h0, 32'hD);
    fifo_level = 7'd5;
    tick();
    for (int i = 0; i < 10; i++) strobe_word(1'b0);
    wr(4'h0, 32'hE);
    repeat (3) tick();
    check("drain_hold", 32'(send_ctrl), 32'd5);
    strobe_word(1'b0);
    check("drain_off", 32'(send_ctrl), 32'd0);
    apb_read(4'h8, rd); check("drain_status", rd, 32'h000B_0002);
    wr(4'h8, 32'h2);

    // 4: underrun coinciding with length reached
    wr(4'h4, 32'd2);
    wr(4'h0, 32'h4);
    wr(4'h0, 32'h5);
    tick();
    strobe_word(1'b0);
    strobe_word(1'b1);
    check("underrun_busy", 32'(busy), 32'd0);
    apb_read(4'h8, rd); check("underrun_status", rd, 32'h0002_0004);
    wr(4'h8, 32'h4);

    // 5: stop while priming
    wr(4'h4, 32'd3);
    wr(4'hC, 32'd8);
    wr(4'h0, 32'h5);
    fifo_level = 7'd2;
    repeat (3) tick();
    wr(4'h0, 32'h6);
    check("prime_stop_busy", 32'(busy), 32'd0);
    apb_read(4'h8, rd); check("prime_stop_status", rd, 32'h0000_0000);

    // 6: asynchronous reset mid-run
    wr(4'hC, 32'd3);
    wr(4'h4, 32'd5);
    wr(4'h0, 32'h5);
    fifo_level = 7'd5;
    tick();
    strobe_word(1'b0);
    check("pre_reset_send", 32'(send_ctrl), 32'd5);
    rst = 1'b0;
    #1;
    check("async_reset_send", 32'(send_ctrl), 32'd0);
    check("async_reset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    apb_read(4'hC, rd); check("post_reset_thresh", rd, 32'd1);
    apb_read(4'h4, rd); check("post_reset_len", rd, 32'd0);
    apb_read(4'h0, rd); check("post_reset_ctrl", rd, 32'd0);
    apb_read(4'h8, rd); check("post_reset_status", rd, 32'd0);

    // randomized runs
    for (int it = 0; it < 30; it++) begin
      cont_r   = ($urandom_range(0, 3) == 0);
      irq_en_r = $urandom_range(0, 1);
      wr(4'h4, 32'($urandom_range(1, 6)));
      wr(4'hC, 32'($urandom_range(1, 10)));
      wr(4'h0, {28'b0, cont_r, irq_en_r, 2'b01});
      for (int c = 0; c < 80 && m_active; c++) begin
        fifo_level  = 7'($urandom_range(0, 15));
        fifo_empty  = ($urandom_range(0, 11) == 0);
        word_strobe = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 29) == 0)
          wr(4'h0, {28'b0, cont_r, irq_en_r, 2'b10});
        else
          tick();
      end
      fifo_empty = 1'b0;
      if (m_active) wr(4'h0, {28'b0, cont_r, irq_en_r, 2'b10});
      fifo_level = 7'd15;
      for (int c = 0; c < 40 && busy; c++) strobe_word(1'b0);
      check("random_run_ended", 32'(busy), 32'd0);
      apb_read(4'h8, rd);
      apb_read(4'h0, rd);
      wr(4'h8, 32'($urandom_range(0, 7)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
